// File: rtl/mrv1_fu_wb_collect.sv
// ---------------------------------------------------------------------------
// mrv1_fu_wb_collect
//
// Purpose:
//   Collects fire-and-forget completion strobes from NUM_SRC_P functional
//   units, buffers each source in its own small circular FIFO and serializes
//   the buffered results onto a single valid/ready writeback port. The FU
//   side has no backpressure, so each FIFO exports a full flag to issue logic.
//   A completion that arrives at a full FIFO that is not being drained in
//   the same cycle is dropped, and the sticky overflow flag is raised.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   src_done_i  per-source completion strobe
//   src_res_i   per-source result,  source s at [s*DATA_WIDTH_P +: DATA_WIDTH_P]
//   src_itag_i  per-source itag,    same packing
//   src_tid_i   per-source thread,  same packing
//   src_full_o  per-source FIFO full (registered state only)
//   wb_valid_o  writeback entry available (never depends on wb_ready_i)
//   wb_ready_i  consumer accepts the presented entry
//   wb_data_o   writeback result      (0 when wb_valid_o is low)
//   wb_itag_o   writeback itag        (0 when wb_valid_o is low)
//   wb_tid_o    writeback thread id   (0 when wb_valid_o is low)
//   wb_src_o    originating source    (0 when wb_valid_o is low)
//   overflow_o  sticky: a completion was dropped since reset
//
// NUM_THREADS_P has no meaningful default; every instance must set it.
// ---------------------------------------------------------------------------
module mrv1_fu_wb_collect #(
  parameter  int DATA_WIDTH_P  = 32,
  parameter  int ITAG_WIDTH_P  = 3,
  parameter  int NUM_THREADS_P = 4,
  parameter  int NUM_SRC_P     = 3,
  parameter  int FIFO_DEPTH_P  = 2,
  localparam int TID_WIDTH_LP  = $clog2(NUM_THREADS_P),
  localparam int SRC_WIDTH_LP  = $clog2(NUM_SRC_P)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_SRC_P-1:0]              src_done_i,
  input  logic [NUM_SRC_P*DATA_WIDTH_P-1:0] src_res_i,
  input  logic [NUM_SRC_P*ITAG_WIDTH_P-1:0] src_itag_i,
  input  logic [NUM_SRC_P*TID_WIDTH_LP-1:0] src_tid_i,
  output logic [NUM_SRC_P-1:0]              src_full_o,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [DATA_WIDTH_P-1:0]           wb_data_o,
  output logic [ITAG_WIDTH_P-1:0]           wb_itag_o,
  output logic [TID_WIDTH_LP-1:0]           wb_tid_o,
  output logic [SRC_WIDTH_LP-1:0]           wb_src_o,
  output logic                              overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH_P);
  localparam int CNT_W = $clog2(FIFO_DEPTH_P + 1);
  localparam int ENT_W = DATA_WIDTH_P + ITAG_WIDTH_P + TID_WIDTH_LP;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH_P);

  logic [ENT_W-1:0]        r_mem   [NUM_SRC_P][FIFO_DEPTH_P];
  logic [PTR_W-1:0]        r_wptr  [NUM_SRC_P];
  logic [PTR_W-1:0]        r_rptr  [NUM_SRC_P];
  logic [CNT_W-1:0]        r_count [NUM_SRC_P];
  logic [SRC_WIDTH_LP-1:0] r_last_grant;
  logic [SRC_WIDTH_LP-1:0] r_lock_src;
  logic                    r_locked;
  logic                    r_overflow;

  logic [NUM_SRC_P-1:0]    w_nonempty;
  logic [NUM_SRC_P-1:0]    w_push;
  logic [NUM_SRC_P-1:0]    w_pop;
  logic [NUM_SRC_P-1:0]    w_drop;
  logic [SRC_WIDTH_LP-1:0] w_rr_grant;
  logic [SRC_WIDTH_LP-1:0] w_grant;
  logic                    w_found;
  logic                    w_valid;
  logic                    w_fire;
  logic [ENT_W-1:0]        w_head;
  int                      w_idx;

  // Occupancy-derived flags; full comes from registered count only.
  always_comb begin
    w_nonempty = '0;
    src_full_o = '0;
    for (int s = 0; s < NUM_SRC_P; s++) begin
      w_nonempty[s] = (r_count[s] != '0);
      src_full_o[s] = (r_count[s] == FULL_CNT);
    end
  end

  assign w_valid = |w_nonempty;
  assign w_fire  = w_valid & wb_ready_i;

  // Round-robin search starting just after the last source that completed a
  // handshake.
  always_comb begin
    w_rr_grant = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 1; i <= NUM_SRC_P; i++) begin
      w_idx = (int'(r_last_grant) + i) % NUM_SRC_P;
      if (!w_found && w_nonempty[w_idx]) begin
        w_found    = 1'b1;
        w_rr_grant = SRC_WIDTH_LP'(w_idx);
      end
    end
  end

  // A presented but unaccepted entry keeps its grant, so a newly arriving
  // higher-priority entry cannot change the payload under the consumer.
  assign w_grant = r_locked ? r_lock_src : w_rr_grant;
  assign w_head  = r_mem[w_grant][r_rptr[w_grant]];

  // A full FIFO can still accept a push when its head leaves the same cycle.
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    w_drop = '0;
    for (int s = 0; s < NUM_SRC_P; s++) begin
      w_pop[s]  = w_fire && (w_grant == SRC_WIDTH_LP'(s));
      w_push[s] = src_done_i[s] && ((r_count[s] != FULL_CNT) || w_pop[s]);
      w_drop[s] = src_done_i[s] && !w_push[s];
    end
  end

  assign wb_valid_o = w_valid;
  assign {wb_data_o, wb_itag_o, wb_tid_o} = w_valid ? w_head : '0;
  assign wb_src_o   = w_valid ? w_grant : '0;
  assign overflow_o = r_overflow;

  // Storage array carries no reset; stale contents are never visible because
  // the payload is gated by occupancy.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NUM_SRC_P; s++) begin
      if (w_push[s]) begin
        r_mem[s][r_wptr[s]] <= {src_res_i[s*DATA_WIDTH_P +: DATA_WIDTH_P],
                                src_itag_i[s*ITAG_WIDTH_P +: ITAG_WIDTH_P],
                                src_tid_i[s*TID_WIDTH_LP +: TID_WIDTH_LP]};
      end
    end
  end

  // Pointers, counts, arbitration history and the sticky overflow flag.
  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SRC_P; s++) begin
        r_wptr[s]  <= '0;
        r_rptr[s]  <= '0;
        r_count[s] <= '0;
      end
      r_last_grant <= SRC_WIDTH_LP'(NUM_SRC_P - 1);
      r_lock_src   <= '0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SRC_P; s++) begin
        if (w_push[s]) r_wptr[s] <= r_wptr[s] + PTR_W'(1);
        if (w_pop[s])  r_rptr[s] <= r_rptr[s] + PTR_W'(1);
        if (w_push[s] && !w_pop[s])      r_count[s] <= r_count[s] + CNT_W'(1);
        else if (!w_push[s] && w_pop[s]) r_count[s] <= r_count[s] - CNT_W'(1);
      end
      if (w_fire) r_last_grant <= w_grant;
      r_locked   <= w_valid & ~wb_ready_i;
      r_lock_src <= w_grant;
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

endmodule
